// File: rtl/mipi_csi_rx_pkg.sv
// Shared types and constants for the CSI-2 receive lane path.
package mipi_csi_rx_pkg;

  // Per-packet sequencer states for the lane sync controller.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARM    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    ERR    = 3'd4
  } lane_sync_state_t;

  // Depth of the downstream lane aligner FIFO; skew limits must stay below it.
  localparam int ALIGN_DEPTH = 7;

endpackage : mipi_csi_rx_pkg

// File: rtl/mipi_csi_rx_lane_sync_ctrl.sv
// Lane sync controller: gates per-lane byte valids into the CSI-2 aligner,
// measures start/end inter-lane skew, flushes the aligner on errors and
// counts good packets. Byte data never passes through here.
//
// Handshake note: there is no backpressure. raw_valid_i is a per-lane
// strobe that is forwarded combinationally as bytes_valid_o (masked, and
// forced low in ERR); aligned_valid_i is observed only to detect that the
// aligner output has gone idle during DRAIN.
module mipi_csi_rx_lane_sync_ctrl
  import mipi_csi_rx_pkg::*;
#(
  parameter int MIPI_LANES    = 4,
  parameter int SKEW_W        = 4,
  parameter int DRAIN_TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [MIPI_LANES-1:0] cfg_lane_mask_i,
  input  logic [SKEW_W-1:0]     cfg_max_skew_i,
  input  logic [MIPI_LANES-1:0] raw_valid_i,
  input  logic [MIPI_LANES-1:0] aligned_valid_i,
  output logic [MIPI_LANES-1:0] bytes_valid_o,
  output logic                  aligner_flush_o,
  output logic                  busy_o,
  output logic                  skew_err_o,
  output logic                  timeout_err_o,
  output logic [SKEW_W-1:0]     last_skew_o,
  output logic [15:0]           pkt_count_o,
  output lane_sync_state_t      dbg_state_o
);

  localparam int DCNT_W = $clog2(DRAIN_TIMEOUT) + 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_TIMEOUT - 1);

  lane_sync_state_t      state_q;
  logic [MIPI_LANES-1:0] m_q;
  logic [SKEW_W-1:0]     max_skew_q;
  logic [MIPI_LANES-1:0] seen_q;
  logic [SKEW_W-1:0]     cnt_q;
  logic [SKEW_W-1:0]     tcnt_q;
  logic [DCNT_W-1:0]     dcnt_q;
  logic [SKEW_W-1:0]     last_skew_q;
  logic [15:0]           pkt_count_q;
  logic                  skew_err_q;
  logic                  timeout_err_q;
  logic                  flush_q;

  logic [MIPI_LANES-1:0] mask_sel;
  logic [MIPI_LANES-1:0] v;
  logic [MIPI_LANES-1:0] seen_d;
  logic [SKEW_W-1:0]     cnt_d;
  logic [SKEW_W-1:0]     tcnt_d;

  // In IDLE the live config mask qualifies lanes; afterwards the latched one.
  assign mask_sel = (state_q == IDLE) ? cfg_lane_mask_i : m_q;
  assign v        = raw_valid_i & mask_sel;
  assign seen_d   = seen_q | v;

  // Saturating increments for the start and tail skew counters.
  assign cnt_d  = (cnt_q  == '1) ? cnt_q  : cnt_q  + SKEW_W'(1);
  assign tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + SKEW_W'(1);

  // Zero-latency valid gating; ERR blocks everything until lanes go quiet.
  assign bytes_valid_o   = (state_q == ERR) ? '0 : v;
  assign busy_o          = (state_q != IDLE);
  assign aligner_flush_o = flush_q;
  assign skew_err_o      = skew_err_q;
  assign timeout_err_o   = timeout_err_q;
  assign last_skew_o     = last_skew_q;
  assign pkt_count_o     = pkt_count_q;
  assign dbg_state_o     = state_q;

  // Packet sequencer: state, counters and registered pulse outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      m_q           <= '0;
      max_skew_q    <= '0;
      seen_q        <= '0;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      dcnt_q        <= '0;
      last_skew_q   <= '0;
      pkt_count_q   <= '0;
      skew_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      // Pulses default low so each asserts for exactly one cycle.
      skew_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      flush_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (v != '0) begin
            m_q        <= cfg_lane_mask_i;
            max_skew_q <= cfg_max_skew_i;
            tcnt_q     <= '0;
            if (v == cfg_lane_mask_i) begin
              state_q     <= STREAM;
              last_skew_q <= '0;
            end else begin
              state_q <= ARM;
              seen_q  <= v;
              cnt_q   <= SKEW_W'(1);
            end
          end
        end
        ARM: begin
          seen_q <= seen_d;
          // A lane completing the set wins over a skew error in the same cycle.
          if (seen_d == m_q) begin
            state_q     <= STREAM;
            last_skew_q <= cnt_q;
            tcnt_q      <= '0;
          end else if (cnt_q > max_skew_q) begin
            state_q    <= ERR;
            skew_err_q <= 1'b1;
            flush_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        STREAM: begin
          if (v == '0) begin
            state_q <= DRAIN;
            dcnt_q  <= '0;
          end else if (v == m_q) begin
            tcnt_q <= '0;
          end else begin
            // Partial tail: the count after this cycle is the running end skew.
            tcnt_q <= tcnt_d;
            if (tcnt_d > max_skew_q) begin
              state_q    <= ERR;
              skew_err_q <= 1'b1;
              flush_q    <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Idle aligner takes priority over an expiring timeout.
          if (aligned_valid_i == '0) begin
            state_q     <= IDLE;
            pkt_count_q <= pkt_count_q + 16'd1;
          end else if (dcnt_q == DCNT_LAST) begin
            state_q       <= IDLE;
            timeout_err_q <= 1'b1;
            flush_q       <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q + DCNT_W'(1);
          end
        end
        ERR: begin
          if (v == '0) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule : mipi_csi_rx_lane_sync_ctrl

// File: tb/tb_mipi_csi_rx_lane_sync_ctrl.sv
// Directed bench for the lane sync controller.
module tb_mipi_csi_rx_lane_sync_ctrl;
  import mipi_csi_rx_pkg::*;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic [3:0]       cfg_lane_mask_i = 4'hF;
  logic [3:0]       cfg_max_skew_i = 4'd0;
  logic [3:0]       raw_valid_i = 4'h0;
  logic [3:0]       aligned_valid_i = 4'h0;
  logic [3:0]       bytes_valid_o;
  logic             aligner_flush_o;
  logic             busy_o;
  logic             skew_err_o;
  logic             timeout_err_o;
  logic [3:0]       last_skew_o;
  logic [15:0]      pkt_count_o;
  lane_sync_state_t dbg_state_o;

  int n_cmp = 0;
  int n_mis = 0;
  int n_skew_p = 0;
  int n_tmo_p = 0;
  int n_flush_p = 0;
  logic [15:0] exp_pkt = 16'd0;

  mipi_csi_rx_lane_sync_ctrl #(
    .MIPI_LANES(4), .SKEW_W(4), .DRAIN_TIMEOUT(16)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .cfg_lane_mask_i(cfg_lane_mask_i),
    .cfg_max_skew_i(cfg_max_skew_i),
    .raw_valid_i(raw_valid_i),
    .aligned_valid_i(aligned_valid_i),
    .bytes_valid_o(bytes_valid_o),
    .aligner_flush_o(aligner_flush_o),
    .busy_o(busy_o),
    .skew_err_o(skew_err_o),
    .timeout_err_o(timeout_err_o),
    .last_skew_o(last_skew_o),
    .pkt_count_o(pkt_count_o),
    .dbg_state_o(dbg_state_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Pulse monitors, sampled mid-cycle.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (skew_err_o) n_skew_p++;
      if (timeout_err_o) n_tmo_p++;
      if (aligner_flush_o) n_flush_p++;
    end
  end

  // Apply inputs for one clock, return 2ns after the edge that consumed them.
  task automatic step(input logic [3:0] raw, input logic [3:0] al);
    raw_valid_i = raw;
    aligned_valid_i = al;
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset;
    raw_valid_i = 4'h0;
    repeat (3) @(posedge clk_i);
    #2;
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL reset_state: got %0d want %0d", dbg_state_o, IDLE); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (bytes_valid_o !== 4'h0) begin n_mis++; $display("FAIL reset_bytes: got %h want 0", bytes_valid_o); end
    n_cmp++; if (aligner_flush_o !== 1'b0) begin n_mis++; $display("FAIL reset_flush: got %b want 0", aligner_flush_o); end
    n_cmp++; if (skew_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_skew_err: got %b want 0", skew_err_o); end
    n_cmp++; if (timeout_err_o !== 1'b0) begin n_mis++; $display("FAIL reset_timeout: got %b want 0", timeout_err_o); end
    n_cmp++; if (last_skew_o !== 4'd0) begin n_mis++; $display("FAIL reset_last_skew: got %0d want 0", last_skew_o); end
    n_cmp++; if (pkt_count_o !== 16'd0) begin n_mis++; $display("FAIL reset_pkt: got %0d want 0", pkt_count_o); end
    reset_i = 1'b0;
    step(4'h0, 4'h0);
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL post_reset_idle: got %0d want %0d", dbg_state_o, IDLE); end
  endtask

  task automatic test_aligned_start;
    int s0, t0, f0;
    s0 = n_skew_p; t0 = n_tmo_p; f0 = n_flush_p;
    cfg_lane_mask_i = 4'hF; cfg_max_skew_i = 4'd2;
    step(4'hF, 4'h0);
    n_cmp++; if (dbg_state_o !== STREAM) begin n_mis++; $display("FAIL aligned_skip_arm: got %0d want %0d", dbg_state_o, STREAM); end
    n_cmp++; if (busy_o !== 1'b1) begin n_mis++; $display("FAIL aligned_busy: got %b want 1", busy_o); end
    repeat (19) step(4'hF, 4'h0);
    n_cmp++; if (dbg_state_o !== STREAM) begin n_mis++; $display("FAIL aligned_stream_hold: got %0d want %0d", dbg_state_o, STREAM); end
    step(4'h0, 4'hF);
    n_cmp++; if (dbg_state_o !== DRAIN) begin n_mis++; $display("FAIL aligned_drain: got %0d want %0d", dbg_state_o, DRAIN); end
    step(4'h0, 4'hF);
    step(4'h0, 4'hF);
    n_cmp++; if (dbg_state_o !== DRAIN) begin n_mis++; $display("FAIL aligned_drain_hold: got %0d want %0d", dbg_state_o, DRAIN); end
    step(4'h0, 4'h0);
    exp_pkt = exp_pkt + 16'd1;
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL aligned_idle: got %0d want %0d", dbg_state_o, IDLE); end
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL aligned_pkt: got %0d want %0d", pkt_count_o, exp_pkt); end
    n_cmp++; if (last_skew_o !== 4'd0) begin n_mis++; $display("FAIL aligned_last_skew: got %0d want 0", last_skew_o); end
    n_cmp++; if ((n_skew_p - s0) + (n_tmo_p - t0) + (n_flush_p - f0) !== 0) begin n_mis++; $display("FAIL aligned_no_errs: got %0d pulses want 0", (n_skew_p - s0) + (n_tmo_p - t0) + (n_flush_p - f0)); end
  endtask

  task automatic test_legal_skew;
    logic [3:0] vec [4];
    lane_sync_state_t exp_st [4];
    vec = '{4'h1, 4'h3, 4'h7, 4'hF};
    exp_st = '{ARM, ARM, ARM, STREAM};
    cfg_lane_mask_i = 4'hF; cfg_max_skew_i = 4'd3;
    for (int i = 0; i < 4; i++) begin
      raw_valid_i = vec[i];
      #1;
      n_cmp++; if (bytes_valid_o !== vec[i]) begin n_mis++; $display("FAIL legal_bytes_%0d: got %h want %h", i, bytes_valid_o, vec[i]); end
      step(vec[i], 4'h0);
      n_cmp++; if (dbg_state_o !== exp_st[i]) begin n_mis++; $display("FAIL legal_state_%0d: got %0d want %0d", i, dbg_state_o, exp_st[i]); end
    end
    n_cmp++; if (last_skew_o !== 4'd3) begin n_mis++; $display("FAIL legal_last_skew: got %0d want 3", last_skew_o); end
    for (int i = 0; i < 3; i++) begin
      raw_valid_i = 4'hF;
      #1;
      n_cmp++; if (bytes_valid_o !== 4'hF) begin n_mis++; $display("FAIL legal_stream_bytes_%0d: got %h want f", i, bytes_valid_o); end
      step(4'hF, 4'h0);
    end
    raw_valid_i = 4'h0;
    #1;
    n_cmp++; if (bytes_valid_o !== 4'h0) begin n_mis++; $display("FAIL legal_tail_bytes: got %h want 0", bytes_valid_o); end
    step(4'h0, 4'h0);
    step(4'h0, 4'h0);
    exp_pkt = exp_pkt + 16'd1;
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL legal_pkt: got %0d want %0d", pkt_count_o, exp_pkt); end
  endtask

  task automatic test_start_skew_violation;
    int s0, f0;
    s0 = n_skew_p; f0 = n_flush_p;
    cfg_lane_mask_i = 4'hF; cfg_max_skew_i = 4'd2;
    step(4'h7, 4'h0);
    step(4'h7, 4'h0);
    step(4'h7, 4'h0);
    n_cmp++; if (dbg_state_o !== ARM) begin n_mis++; $display("FAIL sv_arm_at_max: got %0d want %0d", dbg_state_o, ARM); end
    step(4'h7, 4'h0);
    n_cmp++; if (dbg_state_o !== ERR) begin n_mis++; $display("FAIL sv_err_state: got %0d want %0d", dbg_state_o, ERR); end
    n_cmp++; if (skew_err_o !== 1'b1) begin n_mis++; $display("FAIL sv_skew_pulse: got %b want 1", skew_err_o); end
    n_cmp++; if (aligner_flush_o !== 1'b1) begin n_mis++; $display("FAIL sv_flush_pulse: got %b want 1", aligner_flush_o); end
    n_cmp++; if (bytes_valid_o !== 4'h0) begin n_mis++; $display("FAIL sv_bytes_gated: got %h want 0", bytes_valid_o); end
    raw_valid_i = 4'hF;
    #1;
    n_cmp++; if (bytes_valid_o !== 4'h0) begin n_mis++; $display("FAIL sv_bytes_gated_full: got %h want 0", bytes_valid_o); end
    step(4'hF, 4'h0);
    n_cmp++; if (skew_err_o !== 1'b0) begin n_mis++; $display("FAIL sv_pulse_end: got %b want 0", skew_err_o); end
    step(4'hF, 4'h0);
    n_cmp++; if (dbg_state_o !== ERR) begin n_mis++; $display("FAIL sv_err_hold: got %0d want %0d", dbg_state_o, ERR); end
    step(4'h0, 4'h0);
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL sv_back_idle: got %0d want %0d", dbg_state_o, IDLE); end
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL sv_pkt_unchanged: got %0d want %0d", pkt_count_o, exp_pkt); end
    n_cmp++; if (n_skew_p - s0 !== 1) begin n_mis++; $display("FAIL sv_skew_count: got %0d want 1", n_skew_p - s0); end
    n_cmp++; if (n_flush_p - f0 !== 1) begin n_mis++; $display("FAIL sv_flush_count: got %0d want 1", n_flush_p - f0); end
    n_cmp++; if (last_skew_o !== 4'd3) begin n_mis++; $display("FAIL sv_last_skew_kept: got %0d want 3", last_skew_o); end
  endtask

  task automatic test_tail_skew_violation;
    int s0;
    s0 = n_skew_p;
    cfg_lane_mask_i = 4'hF; cfg_max_skew_i = 4'd2;
    step(4'hF, 4'h0);
    step(4'hF, 4'h0);
    step(4'h4, 4'h0);
    step(4'h4, 4'h0);
    n_cmp++; if (dbg_state_o !== STREAM) begin n_mis++; $display("FAIL tail_within_limit: got %0d want %0d", dbg_state_o, STREAM); end
    step(4'h4, 4'h0);
    n_cmp++; if (dbg_state_o !== ERR) begin n_mis++; $display("FAIL tail_err: got %0d want %0d", dbg_state_o, ERR); end
    n_cmp++; if (skew_err_o !== 1'b1) begin n_mis++; $display("FAIL tail_skew_pulse: got %b want 1", skew_err_o); end
    step(4'h4, 4'h0);
    step(4'h4, 4'h0);
    n_cmp++; if (dbg_state_o !== ERR) begin n_mis++; $display("FAIL tail_err_hold: got %0d want %0d", dbg_state_o, ERR); end
    step(4'h0, 4'h0);
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL tail_idle: got %0d want %0d", dbg_state_o, IDLE); end
    n_cmp++; if (n_skew_p - s0 !== 1) begin n_mis++; $display("FAIL tail_skew_count: got %0d want 1", n_skew_p - s0); end
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL tail_pkt_unchanged: got %0d want %0d", pkt_count_o, exp_pkt); end
  endtask

  task automatic test_drain_timeout;
    int t0;
    t0 = n_tmo_p;
    cfg_lane_mask_i = 4'hF; cfg_max_skew_i = 4'd2;
    step(4'hF, 4'h0);
    step(4'hF, 4'h0);
    step(4'h0, 4'hF);
    repeat (15) step(4'h0, 4'hF);
    n_cmp++; if (dbg_state_o !== DRAIN) begin n_mis++; $display("FAIL tmo_drain_15: got %0d want %0d", dbg_state_o, DRAIN); end
    n_cmp++; if (timeout_err_o !== 1'b0) begin n_mis++; $display("FAIL tmo_early: got %b want 0", timeout_err_o); end
    step(4'h0, 4'hF);
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL tmo_idle: got %0d want %0d", dbg_state_o, IDLE); end
    n_cmp++; if (timeout_err_o !== 1'b1) begin n_mis++; $display("FAIL tmo_pulse: got %b want 1", timeout_err_o); end
    n_cmp++; if (aligner_flush_o !== 1'b1) begin n_mis++; $display("FAIL tmo_flush: got %b want 1", aligner_flush_o); end
    step(4'h0, 4'h0);
    n_cmp++; if (n_tmo_p - t0 !== 1) begin n_mis++; $display("FAIL tmo_count: got %0d want 1", n_tmo_p - t0); end
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL tmo_pkt_unchanged: got %0d want %0d", pkt_count_o, exp_pkt); end
  endtask

  task automatic test_drain_tie;
    int t0;
    t0 = n_tmo_p;
    step(4'hF, 4'h0);
    step(4'h0, 4'hF);
    repeat (15) step(4'h0, 4'hF);
    step(4'h0, 4'h0);
    exp_pkt = exp_pkt + 16'd1;
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL tie_idle: got %0d want %0d", dbg_state_o, IDLE); end
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL tie_pkt: got %0d want %0d", pkt_count_o, exp_pkt); end
    n_cmp++; if (n_tmo_p - t0 !== 0) begin n_mis++; $display("FAIL tie_no_timeout: got %0d want 0", n_tmo_p - t0); end
  endtask

  task automatic test_two_lane_mask;
    logic [3:0] vec [5];
    vec = '{4'hF, 4'h7, 4'hB, 4'h3, 4'hF};
    cfg_lane_mask_i = 4'h3; cfg_max_skew_i = 4'd2;
    for (int i = 0; i < 5; i++) begin
      raw_valid_i = vec[i];
      #1;
      n_cmp++; if (bytes_valid_o !== 4'h3) begin n_mis++; $display("FAIL mask2_bytes_%0d: got %h want 3", i, bytes_valid_o); end
      step(vec[i], 4'h0);
      // Widen the configured mask mid-packet; it must not apply yet.
      cfg_lane_mask_i = 4'hF;
    end
    n_cmp++; if (dbg_state_o !== STREAM) begin n_mis++; $display("FAIL mask2_stream: got %0d want %0d", dbg_state_o, STREAM); end
    raw_valid_i = 4'hC;
    #1;
    n_cmp++; if (bytes_valid_o !== 4'h0) begin n_mis++; $display("FAIL mask2_upper_gated: got %h want 0", bytes_valid_o); end
    step(4'hC, 4'h0);
    n_cmp++; if (dbg_state_o !== DRAIN) begin n_mis++; $display("FAIL mask2_drain: got %0d want %0d", dbg_state_o, DRAIN); end
    step(4'hC, 4'h0);
    exp_pkt = exp_pkt + 16'd1;
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL mask2_pkt: got %0d want %0d", pkt_count_o, exp_pkt); end
    step(4'h3, 4'h0);
    n_cmp++; if (dbg_state_o !== ARM) begin n_mis++; $display("FAIL mask4_arm: got %0d want %0d", dbg_state_o, ARM); end
    step(4'hF, 4'h0);
    n_cmp++; if (last_skew_o !== 4'd1) begin n_mis++; $display("FAIL mask4_last_skew: got %0d want 1", last_skew_o); end
    step(4'h0, 4'h0);
    step(4'h0, 4'h0);
    exp_pkt = exp_pkt + 16'd1;
    n_cmp++; if (pkt_count_o !== exp_pkt) begin n_mis++; $display("FAIL mask4_pkt: got %0d want %0d", pkt_count_o, exp_pkt); end
  endtask

  task automatic test_reset_mid_stream;
    cfg_lane_mask_i = 4'hF; cfg_max_skew_i = 4'd2;
    step(4'h1, 4'h0);
    step(4'hF, 4'h0);
    step(4'hF, 4'h0);
    n_cmp++; if (dbg_state_o !== STREAM) begin n_mis++; $display("FAIL rst_pre_stream: got %0d want %0d", dbg_state_o, STREAM); end
    raw_valid_i = 4'h0;
    reset_i = 1'b1;
    #1;
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL rst_async_idle: got %0d want %0d", dbg_state_o, IDLE); end
    n_cmp++; if (busy_o !== 1'b0) begin n_mis++; $display("FAIL rst_async_busy: got %b want 0", busy_o); end
    n_cmp++; if (last_skew_o !== 4'd0) begin n_mis++; $display("FAIL rst_async_last_skew: got %0d want 0", last_skew_o); end
    n_cmp++; if (pkt_count_o !== 16'd0) begin n_mis++; $display("FAIL rst_async_pkt: got %0d want 0", pkt_count_o); end
    n_cmp++; if ({aligner_flush_o, skew_err_o, timeout_err_o} !== 3'b000) begin n_mis++; $display("FAIL rst_async_pulses: got %b want 000", {aligner_flush_o, skew_err_o, timeout_err_o}); end
    n_cmp++; if (bytes_valid_o !== 4'h0) begin n_mis++; $display("FAIL rst_async_bytes: got %h want 0", bytes_valid_o); end
    raw_valid_i = 4'hF;
    #1;
    n_cmp++; if (bytes_valid_o !== 4'hF) begin n_mis++; $display("FAIL rst_passes_v: got %h want f", bytes_valid_o); end
    @(posedge clk_i);
    #2;
    reset_i = 1'b0;
    exp_pkt = 16'd0;
    step(4'h0, 4'h0);
    n_cmp++; if (dbg_state_o !== IDLE) begin n_mis++; $display("FAIL rst_release_idle: got %0d want %0d", dbg_state_o, IDLE); end
  endtask

  initial begin
    test_reset();
    test_aligned_start();
    test_legal_skew();
    test_start_skew_violation();
    test_tail_skew_violation();
    test_drain_timeout();
    test_drain_tie();
    test_two_lane_mask();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_mipi_csi_rx_lane_sync_ctrl
